// File: rtl/serial_word_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_collector_pkg
// Description : Shared constants and state type for the serial word collector.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_word_collector_pkg;

    // Word geometry of the bit-serial link
    localparam int WORD_W   = 16;
    localparam int IDX_W    = 4;
    localparam int LAST_IDX = WORD_W - 1;

    // Collector states: IDLE = no partial word, ACCUM = partial word held
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage : serial_word_collector_pkg
`default_nettype wire

// File: rtl/serial_word_collector_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_collector_hold_reg
// Description : Valid/ready output register for completed words. A new word
//               loads when the register is empty or is being drained in the
//               same cycle; otherwise it is dropped and overrun is flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_collector_hold_reg
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    // Holding register with handshake; a set of overrun wins over clr_err
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (clr_err) begin
                r_overrun <= 1'b0;
            end
            if (load) begin
                if (!r_valid || out_ready) begin
                    r_data  <= word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule : serial_word_collector_hold_reg
`default_nettype wire

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_collector
// Description : Receive end of the bit-serial word link. Accumulates bits
//               LSB first into a word, hands completed words to a valid/ready
//               output register and flags framing errors and overruns.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_collector
    import serial_word_collector_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int IDX_W = serial_word_collector_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic [IDX_W-1:0] idx,
    output logic             overrun,
    output logic             frame_err
);

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] C_ONE  = IDX_W'(1);

    // The top bit of a word never sits in the accumulator: it arrives with
    // the completing bit and goes straight to the output register.
    logic [WIDTH-2:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    state_t           r_state;
    logic             r_frame_err;

    logic             w_word_done;
    logic [WIDTH-1:0] w_word;

    assign w_word_done = rst && sin_valid && !sof && (r_idx == C_LAST);
    assign w_word      = {sin, r_acc};

    // Bit accumulator, index counter, collector FSM and framing-error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc       <= '0;
            r_idx       <= '0;
            r_state     <= IDLE;
            r_frame_err <= 1'b0;
        end else begin
            if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (sin_valid) begin
                if (sof) begin
                    // A start of frame mid-word discards the partial word
                    if (r_state == ACCUM) begin
                        r_frame_err <= 1'b1;
                    end
                    r_acc   <= {{(WIDTH-2){1'b0}}, sin};
                    r_idx   <= C_ONE;
                    r_state <= ACCUM;
                end else if (r_idx == C_LAST) begin
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_acc[r_idx] <= sin;
                    r_idx        <= r_idx + C_ONE;
                    r_state      <= ACCUM;
                end
            end
        end
    end

    serial_word_collector_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (w_word_done),
        .word      (w_word),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    assign busy      = (r_state == ACCUM);
    assign idx       = r_idx;
    assign frame_err = r_frame_err;

endmodule : serial_word_collector
`default_nettype wire

// File: tb/tb_serial_word_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_collector
// Description : Self-checking bench: directed scenarios plus random traffic,
//               compared each cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_collector;

    localparam int WIDTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sin = 1'b0;
    logic              sin_valid = 1'b0;
    logic              sof = 1'b0;
    logic              out_ready = 1'b0;
    logic              clr_err = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              busy;
    logic [3:0]        idx;
    logic              overrun;
    logic              frame_err;

    serial_word_collector dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_valid (sin_valid),
        .sof       (sof),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .idx       (idx),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits of the current partial word and the output slot
    bit          m_bits[$];
    logic [15:0] m_data  = '0;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_ferr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit sv, input bit s, input bit f, input bit rdy,
                         input bit clr, input bit nrst);
        bit          done;
        logic [15:0] w;
        done = 1'b0;
        w    = '0;
        if (!nrst) begin
            m_bits.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            if (clr) begin
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
            if (sv) begin
                if (f) begin
                    if (m_bits.size() != 0) m_ferr = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(s);
                end else begin
                    m_bits.push_back(s);
                    if (m_bits.size() == WIDTH) begin
                        for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
                        m_bits.delete();
                        done = 1'b1;
                    end
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_data  = w;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // then compare every output shortly after
    task automatic step(input bit sv, input bit s, input bit f, input bit rdy,
                        input bit clr, input bit nrst);
        @(negedge clk);
        sin_valid = sv;
        sin       = s;
        sof       = f;
        out_ready = rdy;
        clr_err   = clr;
        rst       = nrst;
        @(posedge clk);
        model(sv, s, f, rdy, clr, nrst);
        #1;
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy",      32'(busy),      32'(m_bits.size() != 0));
        check("idx",       32'(idx),       32'(m_bits.size()));
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [15:0] w, input bit rdy, input bit gap);
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[i], i == 0, rdy, 1'b0, 1'b1);
            if (gap && i < WIDTH - 1) step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int first_pulse;
        int cyc;
        // Reset with sin_valid asserted
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_data",  32'(out_data), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_idx",   32'(idx), 32'h0);

        // Single word with continuous input
        send_word(16'hA5C3, 1'b1, 1'b0);
        check("single_data",  32'(out_data), 32'hA5C3);
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_idx",   32'(idx), 32'h0);
        idle(2, 1'b1);

        // Gapped input
        send_word(16'h0F0F, 1'b1, 1'b1);
        check("gap_data", 32'(out_data), 32'h0F0F);
        idle(2, 1'b1);

        // Back-to-back words; pulses must be WIDTH cycles apart
        first_pulse = -1;
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            logic [15:0] w;
            w = (k == 0) ? 16'h1234 : 16'hFFFF;
            for (int i = 0; i < WIDTH; i++) begin
                step(1'b1, w[i], i == 0, 1'b1, 1'b0, 1'b1);
                cyc++;
                if (out_valid && first_pulse < 0) first_pulse = cyc;
            end
        end
        check("b2b_data",    32'(out_data), 32'hFFFF);
        check("b2b_spacing", 32'(cyc - first_pulse), 32'(WIDTH));
        check("b2b_overrun", 32'(overrun), 32'h0);
        idle(2, 1'b1);

        // Overrun with consumer stalled
        send_word(16'h1111, 1'b0, 1'b0);
        send_word(16'h2222, 1'b0, 1'b0);
        check("ovr_data", 32'(out_data), 32'h1111);
        check("ovr_flag", 32'(overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ovr_clr", 32'(overrun), 32'h0);
        idle(2, 1'b1);

        // Resync: partial word then a fresh frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b1, 1'b0, 1'b1);
        send_word(16'hBEEF, 1'b1, 1'b0);
        check("resync_ferr", 32'(frame_err), 32'h1);
        check("resync_data", 32'(out_data), 32'hBEEF);
        idle(2, 1'b1);

        // Reset in the middle of a word
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, i == 0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_idx", 32'(idx), 32'h0);
        idle(20, 1'b1);
        check("midrst_valid", 32'(out_valid), 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 80, 1'($urandom),
                 $urandom_range(99) < 5, $urandom_range(99) < 70,
                 $urandom_range(99) < 3, $urandom_range(499) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_serial_word_collector
`default_nettype wire

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Receive end of the team's bit-serial word link. The transmit end is a mux16 plus a counter that sends word bits 0..15 in order.
- Collects one bit per accepted clock into an internal accumulator, indexed like the demux16 select.
- Presents each completed 16-bit word on a valid/ready output register for the ALU datapath.
- Detects framing errors and overruns.

Parameters:
- WIDTH, 16, bits per word; must be a power of two and at least 2.
- IDX_W, 4, bit-index width, equal to log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous active-low reset; rst==0 at a rising edge of clk resets the block.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sof  input  1  start of frame; meaningful only when sin_valid=1; marks sin as bit 0 of a new word.
- out_ready  input  1  consumer accepts out_data this cycle.
- clr_err  input  1  clears the sticky error flags.
- out_data  output  WIDTH  completed word; bit i is the i-th received bit (LSB first).
- out_valid  output  1  out_data holds an unconsumed word.
- busy  output  1  a partial word is being accumulated (state ACCUM).
- idx  output  IDX_W  index where the next bit will land.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: sof arrived mid-word.

Behaviour:
- Reset (rst==0 at a clock edge): acc=0, idx=0, out_data=0, out_valid=0, busy=0, overrun=0, frame_err=0, state=IDLE. Reset mid-word discards the partial word and any held word.
- FSM states: IDLE and ACCUM.
  - IDLE -> ACCUM on an accepted bit, unless WIDTH bits complete in that same cycle.
  - ACCUM -> IDLE when the bit at idx==WIDTH-1 is accepted.
  - sin_valid=0: all accumulator state holds.
- Accepted bit with sof=0: acc[idx] <= sin; idx <= idx+1, wrapping modulo WIDTH.
- Accepted bit with sof=1: acc <= {0..., sin}; idx <= 1; state=ACCUM.
  - If state was ACCUM (idx != 0), frame_err <= 1 and the partial word is discarded.
  - sof in IDLE is normal and sets no error.
- Word completion: the bit accepted at idx==WIDTH-1 completes the word.
  - The completed word is {sin, acc[WIDTH-2:0]}.
  - acc clears to 0 and idx wraps to 0.
  - Latency: out_valid=1 and out_data=word in the cycle after the last bit's edge.
- Output handshake: a transfer occurs at an edge where out_valid && out_ready.
  - out_valid and out_data are stable until that transfer.
  - out_ready while out_valid=0 has no effect.
- Simultaneous completion and transfer in one cycle: the new word loads and out_valid stays 1. No bubble, no overrun.
- Completion while out_valid=1 and out_ready=0: the new word is dropped, out_data is kept, overrun <= 1. The accumulator still resets to idx 0.
- Error flags:
  - clr_err=1 clears overrun and frame_err.
  - If a set condition occurs in the same cycle as clr_err, set wins.
- Throughput: one word per WIDTH cycles with continuous sin_valid and out_ready held high.

Decomposition:
- Shared package holds:
  - WORD_W=16 and IDX_W=4 constants;
  - the state enum {IDLE, ACCUM};
  - a helper constant LAST_IDX = WORD_W-1.
- One natural sub-module: word_hold_reg, the valid/ready output register with overrun detection.
- The bit-index counter and accumulator stay in the top module.

Test Plan:
- Reset: drive rst=0 for 2 cycles with sin_valid=1 -> out_valid=0, idx=0, busy=0, out_data=16'h0000, both error flags 0.
- Single word: send sof=1 then bits LSB-first of 16'hA5C3, sin_valid=1 continuous, out_ready=1 -> out_valid=1 one cycle after the 16th bit with out_data=16'hA5C3; idx=0.
- Gapped input: send 16'h0F0F with sin_valid=0 inserted every other cycle -> out_data=16'h0F0F after 31 cycles; idx holds during the gaps.
- Back-to-back: send 16'h1234 then 16'hFFFF continuously, out_ready=1 -> two single-cycle out_valid pulses 16 cycles apart; overrun=0.
- Overrun: out_ready=0, send 16'h1111 then 16'h2222 -> out_data stays 16'h1111, overrun=1; clr_err pulse -> overrun=0.
- Resync: send 5 bits, then sof=1 followed by a full 16'hBEEF -> frame_err=1, out_data=16'hBEEF. Also rst=0 at bit 7 of a word -> idx=0 and no word is produced.
